// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op encodings shared with the control unit, core FSM states, default width
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    typedef logic [1:0] alu_op_t;

    localparam alu_op_t OP_ADD = 2'b00;
    localparam alu_op_t OP_SUB = 2'b01;
    localparam alu_op_t OP_MUL = 2'b10;
    localparam alu_op_t OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } alu_state_t;

endpackage

// File: rtl/alu_iter_step.sv
// rtl/alu_iter_step.sv - one MUL add-shift or DIV compare-subtract-shift iteration (DIV path under ALU_SEQ_DIV_EN)
module alu_iter_step
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             op_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    // MUL: hi is the partial-product accumulator, lo the remaining multiplier bits
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;

    assign mul_sum = lo[0] ? ({1'b0, hi} + {1'b0, operand}) : {1'b0, hi};
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], lo[WIDTH-1:1]};

`ifdef ALU_SEQ_DIV_EN
    // DIV: hi is the partial remainder, lo the dividend shifting out / quotient shifting in
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] diff;

    assign shifted = {hi, lo[WIDTH-1]};
    assign ge      = shifted >= {1'b0, operand};
    assign diff    = shifted[WIDTH-1:0] - operand;

    always_comb begin
        hi_next = mul_hi;
        lo_next = mul_lo;
        if (op_div) begin
            hi_next = ge ? diff : shifted[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], ge};
        end
    end
`else
    logic unused_op_div;
    assign unused_op_div = op_div;

    always_comb begin
        hi_next = mul_hi;
        lo_next = mul_lo;
    end
`endif

endmodule

// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - iterative 8-bit ADD/SUB/MUL/DIV execution core; divider present only with ALU_SEQ_DIV_EN
module alu_seq_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    alu_state_t       state;
    alu_op_t          op_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH:0]   add_sum;

    assign add_sum = {1'b0, a} + {1'b0, b};

    alu_iter_step #(.WIDTH(WIDTH)) u_step (
        .op_div  (op_q == OP_DIV),
        .hi      (acc_hi),
        .lo      (acc_lo),
        .operand (operand),
        .hi_next (step_hi),
        .lo_next (step_lo)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            op_q      <= OP_ADD;
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            operand   <= '0;
            result_lo <= '0;
            result_hi <= '0;
            flag      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q <= alu_op;
                        busy <= 1'b1;
                        case (alu_op)
                            OP_ADD: begin
                                result_lo <= add_sum[WIDTH-1:0];
                                result_hi <= {{(WIDTH-1){1'b0}}, add_sum[WIDTH]};
                                flag      <= add_sum[WIDTH];
                                done      <= 1'b1;
                                state     <= ST_DONE;
                            end
                            OP_SUB: begin
                                result_lo <= a - b;
                                result_hi <= '0;
                                flag      <= (a < b);
                                done      <= 1'b1;
                                state     <= ST_DONE;
                            end
                            OP_MUL: begin
                                acc_hi  <= '0;
                                acc_lo  <= b;
                                operand <= a;
                                cnt     <= CW'(WIDTH);
                                state   <= ST_RUN;
                            end
                            default: begin
`ifdef ALU_SEQ_DIV_EN
                                if (b == '0) begin
                                    result_lo <= '1;
                                    result_hi <= a;
                                    flag      <= 1'b1;
                                    done      <= 1'b1;
                                    state     <= ST_DONE;
                                end else begin
                                    acc_hi  <= '0;
                                    acc_lo  <= a;
                                    operand <= b;
                                    cnt     <= CW'(WIDTH);
                                    state   <= ST_RUN;
                                end
`else
                                result_lo <= '0;
                                result_hi <= '0;
                                flag      <= 1'b1;
                                done      <= 1'b1;
                                state     <= ST_DONE;
`endif
                            end
                        endcase
                    end
                end
                ST_RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt - 1'b1;
                    // results are published only once the last iteration lands
                    if (cnt == CW'(1)) begin
                        result_hi <= step_hi;
                        result_lo <= step_lo;
                        flag      <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_core.sv
// tb/tb_alu_seq_core.sv - randomized self-checking bench for alu_seq_core against an arithmetic reference model
module tb_alu_seq_core;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op_in = 2'b00;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic [W-1:0] result_lo;
    logic [W-1:0] result_hi;
    logic         flag;
    logic         busy;
    logic         done;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] m_lo = '0;
    logic [W-1:0] m_hi = '0;
    logic         m_flag = 1'b0;

    alu_seq_core #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .alu_op    (op_in),
        .a         (a_in),
        .b         (b_in),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .flag      (flag),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output logic [W-1:0] lo, output logic [W-1:0] hi,
                         output logic fl);
        int s;
        case (op)
            2'd0: begin
                s = int'(a) + int'(b);
                lo = W'(s); hi = W'(s >> W); fl = (s >= (1 << W)); lat = 1;
            end
            2'd1: begin
                s = int'(a) - int'(b);
                lo = W'(s); hi = '0; fl = (a < b); lat = 1;
            end
            2'd2: begin
                s = int'(a) * int'(b);
                lo = W'(s); hi = W'(s >> W); fl = 1'b0; lat = W + 1;
            end
            default: begin
`ifdef ALU_SEQ_DIV_EN
                if (b == 0) begin
                    lo = '1; hi = a; fl = 1'b1; lat = 1;
                end else begin
                    lo = W'(int'(a) / int'(b)); hi = W'(int'(a) % int'(b)); fl = 1'b0; lat = W + 1;
                end
`else
                lo = '0; hi = '0; fl = 1'b1; lat = 1;
`endif
            end
        endcase
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        int lat;
        logic [W-1:0] lo, hi;
        logic fl;
        model(op, a, b, lat, lo, hi, fl);
        a_in = a; b_in = b; op_in = op; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a_in = W'($urandom); b_in = W'($urandom);
        for (int k = 1; k <= lat; k++) begin
            n_vec++;
            if (busy !== 1'b1) begin
                n_err++; $display("FAIL %s busy c%0d: got %b want 1", name, k, busy);
            end
            n_vec++;
            if (done !== (k == lat)) begin
                n_err++; $display("FAIL %s done c%0d: got %b want %b", name, k, done, (k == lat));
            end
            n_vec++;
            if (k < lat) begin
                if ({result_hi, result_lo, flag} !== {m_hi, m_lo, m_flag}) begin
                    n_err++;
                    $display("FAIL %s hold c%0d: got hi=%h lo=%h f=%b want hi=%h lo=%h f=%b",
                             name, k, result_hi, result_lo, flag, m_hi, m_lo, m_flag);
                end
            end else if ({result_hi, result_lo, flag} !== {hi, lo, fl}) begin
                n_err++;
                $display("FAIL %s result a=%h b=%h: got hi=%h lo=%h f=%b want hi=%h lo=%h f=%b",
                         name, a, b, result_hi, result_lo, flag, hi, lo, fl);
            end
            @(posedge clk); #1;
        end
        m_lo = lo; m_hi = hi; m_flag = fl;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL %s idle: got busy=%b done=%b want 0 0", name, busy, done);
        end
    endtask

    task automatic check_zero(input string name);
        n_vec++;
        if ({result_lo, result_hi, flag, busy, done} !== '0) begin
            n_err++;
            $display("FAIL %s: got lo=%h hi=%h f=%b busy=%b done=%b want all 0",
                     name, result_lo, result_hi, flag, busy, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b1;
        m_lo = '0; m_hi = '0; m_flag = 1'b0;
    endtask

    task automatic test_add_sub();
        run_op("add_200_100", 2'd0, 8'd200, 8'd100);
        run_op("sub_3_5", 2'd1, 8'd3, 8'd5);
        run_op("add_ff_01", 2'd0, 8'hFF, 8'h01);
        run_op("sub_eq", 2'd1, 8'd77, 8'd77);
        for (int i = 0; i < 8; i++)
            run_op("addsub_rand", 2'($urandom_range(0, 1)), W'($urandom), W'($urandom));
    endtask

    task automatic test_mul();
        run_op("mul_255_255", 2'd2, 8'd255, 8'd255);
        run_op("mul_0", 2'd2, 8'd0, 8'd123);
        for (int i = 0; i < 6; i++)
            run_op("mul_rand", 2'd2, W'($urandom), W'($urandom));
    endtask

    task automatic test_div();
        run_op("div_200_7", 2'd3, 8'd200, 8'd7);
        run_op("div_5_9", 2'd3, 8'd5, 8'd9);
        run_op("div_by_zero", 2'd3, 8'h5A, 8'd0);
        run_op("div_255_1", 2'd3, 8'd255, 8'd1);
        for (int i = 0; i < 6; i++)
            run_op("div_rand", 2'd3, W'($urandom), W'($urandom_range(0, 20)));
    endtask

    task automatic test_busy_ignore();
        logic [W-1:0] a, b, lo, hi;
        logic fl;
        int lat;
        a = W'($urandom); b = W'($urandom);
        model(2'd2, a, b, lat, lo, hi, fl);
        a_in = a; b_in = b; op_in = 2'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            if (k == 5) start = 1'b0;
            n_vec++;
            if (done !== (k == lat) || busy !== 1'b1) begin
                n_err++;
                $display("FAIL busy_ignore c%0d: got done=%b busy=%b want %b 1", k, done, busy, (k == lat));
            end
            if (k == 4) begin
                start = 1'b1; op_in = 2'd1; a_in = W'($urandom); b_in = W'($urandom);
            end
            @(posedge clk); #1;
        end
        n_vec++;
        if ({result_hi, result_lo, flag} !== {hi, lo, fl}) begin
            n_err++;
            $display("FAIL busy_ignore result: got hi=%h lo=%h f=%b want hi=%h lo=%h f=%b",
                     result_hi, result_lo, flag, hi, lo, fl);
        end
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL busy_ignore requeued: got busy=%b done=%b want 0 0", busy, done);
        end
        m_lo = lo; m_hi = hi; m_flag = fl;
    endtask

    task automatic test_reset_mid_run();
        a_in = W'($urandom); b_in = W'($urandom); op_in = 2'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            n_vec++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_err++; $display("FAIL reset_mid_run c%0d: got busy=%b done=%b want 1 0", k, busy, done);
            end
            if (k == 5) reset = 1'b0;
            @(posedge clk); #1;
        end
        check_zero("reset_mid_run c6");
        reset = 1'b1;
        m_lo = '0; m_hi = '0; m_flag = 1'b0;
        @(posedge clk); #1;
        check_zero("reset_mid_run settle");
        run_op("after_reset_add", 2'd0, W'($urandom), W'($urandom));
    endtask

    task automatic test_reset_start_same();
        reset = 1'b0; start = 1'b1; op_in = 2'd0; a_in = 8'd9; b_in = 8'd9;
        @(posedge clk); #1;
        reset = 1'b1; start = 1'b0;
        check_zero("reset_wins");
        m_lo = '0; m_hi = '0; m_flag = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] lo, hi, av, bv;
        logic fl;
        int lat;
        op_in = 2'd0; start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            av = W'($urandom); bv = W'($urandom);
            a_in = av; b_in = bv;
            @(posedge clk); #1;
            n_vec++;
            if (done !== (i % 2 == 0) || busy !== (i % 2 == 0)) begin
                n_err++;
                $display("FAIL back_to_back e%0d: got done=%b busy=%b want %b", i, done, busy, (i % 2 == 0));
            end
            if (i % 2 == 0) begin
                model(2'd0, av, bv, lat, lo, hi, fl);
                n_vec++;
                if ({result_hi, result_lo, flag} !== {hi, lo, fl}) begin
                    n_err++;
                    $display("FAIL back_to_back result e%0d: got hi=%h lo=%h f=%b want hi=%h lo=%h f=%b",
                             i, result_hi, result_lo, flag, hi, lo, fl);
                end
                m_lo = lo; m_hi = hi; m_flag = fl;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_random_mix();
        for (int i = 0; i < 24; i++)
            run_op("mix_rand", 2'($urandom_range(0, 3)), W'($urandom), W'($urandom_range(0, 255)));
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_busy_ignore();
        test_reset_mid_run();
        test_reset_start_same();
        test_back_to_back();
        test_random_mix();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq_core.md
# alu_seq_core

Iterative 8-bit execution core sitting directly downstream of the control unit: consumes its `load_alu`/`alu_op` outputs together with the operands and produces the arithmetic result. ADD/SUB complete in one cycle; MUL (shift-add) and DIV (restoring) iterate one bit per cycle. The core raises the completion pulse that the control unit's own `done` deliberately leaves low for MUL/DIV.

## Interface
- `WIDTH`, default 8: operand width; product/quotient-remainder is 2×WIDTH.
- `clk` input, 1: single clock, all state on rising edge.
- `reset` input, 1: synchronous, active-low; clears all state when sampled low.
- `start` input, 1: driven by control unit `load_alu`; request accepted only in IDLE.
- `alu_op` input, 2: 00 = ADD, 01 = SUB, 10 = MUL, 11 = DIV; sampled with `start`.
- `a` input, WIDTH: operand A (dividend for DIV).
- `b` input, WIDTH: operand B (divisor for DIV).
- `result_lo` output, WIDTH: sum, difference, product low half, or quotient.
- `result_hi` output, WIDTH: ADD carry in bit 0, SUB 0, product high half, or remainder.
- `flag` output, 1: ADD carry-out, SUB borrow, MUL 0, DIV divide-by-zero.
- `busy` output, 1: high whenever state ≠ IDLE.
- `done` output, 1: single-cycle completion pulse.

## Operation
- States:
  - IDLE: waits for a request.
  - RUN: iterates, down-counter `cnt` loaded with WIDTH.
  - DONE: one cycle, `done` = 1, then returns to IDLE.
- IDLE with `start` = 1:
  - Operands and op are latched.
  - ADD/SUB: result computed at that edge; go to DONE.
  - MUL/DIV: accumulators initialised; go to RUN.
- MUL: each RUN cycle, if multiplier LSB is set, add the multiplicand into the upper accumulator; shift {acc, multiplier} right one place. After WIDTH iterations, {hi, lo} = a×b (unsigned).
- DIV: each RUN cycle, shift {rem, quo} left; if rem ≥ b, subtract b and set the quotient LSB. Unsigned restoring divide.
- DIV with b = 0: RUN is skipped. Go straight to DONE with `result_lo` = all ones, `result_hi` = a, `flag` = 1.
- Result outputs update only when the final value is ready. Results hold from DONE until the next accepted `start`.
- `start` while `busy` is ignored, not queued. The control unit must re-assert it.
- ADD result width: WIDTH+1 bits, carry in `result_hi[0]`. SUB: `result_lo` = (a − b) mod 2^WIDTH, `flag` = (a < b).

## Timing
- Reset (`reset` low at an edge): state = IDLE; `result_lo`, `result_hi`, `flag`, `busy`, `done` = 0. Takes effect at that edge, including mid-RUN; the iteration is abandoned.
- Accept edge = cycle 0.
  - ADD/SUB and DIV-by-zero: `done` high in cycle 1.
  - MUL/DIV: `busy` high cycles 1..WIDTH+1; `done` high in cycle WIDTH+1 (cycle 9 for WIDTH = 8).
- Throughput: a new `start` is accepted the cycle after DONE (state IDLE).
- `start` held high continuously: re-accepted every other cycle for ADD/SUB.
- `start` and `reset` low at the same edge: reset wins.

## Configuration
- `ALU_SEQ_DIV_EN` defined: divider datapath and DIV behaviour as above.
- Undefined: divider logic removed. DIV acts as an unsupported op: DONE in cycle 1, `result_lo` = `result_hi` = 0, `flag` = 1.

## Structure
- Shared package `alu_pkg`:
  - op encoding constants (`OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_DIV`), common with the control unit;
  - state enum (`ST_IDLE`, `ST_RUN`, `ST_DONE`);
  - `WIDTH` default.
- One sub-module, `alu_iter_step`: combinational single-iteration step (MUL add-shift / DIV compare-subtract-shift) selected by op; instantiated once.
- FSM, counter and registers stay in `alu_seq_core`.

## Test plan
- ADD a = 200, b = 100 → cycle 1: `done` = 1, `result_lo` = 0x2C, `result_hi` = 0x01, `flag` = 1.
- MUL a = 255, b = 255 → `done` only in cycle 9; {hi, lo} = 0xFE01, `flag` = 0; `busy` high cycles 1–9.
- DIV a = 200, b = 7 → cycle 9: `result_lo` = 28, `result_hi` = 4, `flag` = 0. Repeat with a = 5, b = 9 → quotient 0, remainder 5.
- DIV a = 0x5A, b = 0 → cycle 1: `result_lo` = 0xFF, `result_hi` = 0x5A, `flag` = 1. With `ALU_SEQ_DIV_EN` undefined: lo = hi = 0, `flag` = 1.
- MUL started, `start` pulsed with SUB at cycle 4 → SUB ignored; MUL result correct at cycle 9. `reset` low at cycle 5 of a second MUL → cycle 6: all outputs 0, IDLE.
- SUB a = 3, b = 5 → `result_lo` = 0xFE, `result_hi` = 0, `flag` = 1. Back-to-back ADD requests → accepted on alternate cycles.
